// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter signal bundle for uart_tx_arbiter.
// Handshake: req_valid_i[i] is held with stable req_data_i until a one-cycle req_ack_o[i]; ack means the byte went out on tx_data_o.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]        req_valid_i;
    logic [NUM_REQ*DATA_W-1:0] req_data_i;
    logic [NUM_REQ-1:0]        req_lock_i;
    logic [NUM_REQ-1:0]        req_ack_o;
    logic [NUM_REQ-1:0]        grant_o;
    logic [DATA_W-1:0]         tx_data_o;
    logic                      txen_o;
    logic                      tx_ing_i;
    logic                      tx_timeout_o;
    logic                      busy_o;
    // Debug view of the arbiter FSM and round-robin pointer.
    logic [1:0]                state_o;
    logic [PTR_W-1:0]          rr_ptr_o;

    modport master (
        output req_valid_i, req_data_i, req_lock_i, tx_ing_i,
        input  req_ack_o, grant_o, tx_data_o, txen_o, tx_timeout_o, busy_o,
               state_o, rr_ptr_o
    );

    modport slave (
        input  req_valid_i, req_data_i, req_lock_i, tx_ing_i,
        output req_ack_o, grant_o, tx_data_o, txen_o, tx_timeout_o, busy_o,
               state_o, rr_ptr_o
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte sources,
// with locked bursts capped at MAX_BURST and a start timeout on a dead transmitter.
module uart_tx_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int DATA_W        = 8,
    parameter int MAX_BURST     = 16,
    parameter int START_TIMEOUT = 16
) (
    input  logic           clock_i,
    input  logic           reset_i,
    uart_tx_arbiter_if.slave bus
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W:0]       NUM_REQ_W = (PTR_W+1)'(NUM_REQ);
    localparam logic [7:0]           TMO_LAST  = 8'(START_TIMEOUT - 1);
    localparam logic [7:0]           BURST_MAX = 8'(MAX_BURST);
    localparam logic [NUM_REQ-1:0]   ONE_HOT0  = NUM_REQ'(1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        LOAD       = 2'd1,
        WAIT_START = 2'd2,
        WAIT_END   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    rr_q, rr_d, own_q, own_d;
    logic [7:0]          burst_q, burst_d, tmo_q, tmo_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d, ack_q, ack_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                txen_q, txen_d, tout_q, tout_d, busy_q, busy_d;

    logic                win_found;
    logic [PTR_W-1:0]    win_idx;
    logic [PTR_W:0]      scan_sum;
    logic [PTR_W:0]      own_sum;
    logic [PTR_W-1:0]    own_next;
    logic                keep_going;
    logic [DATA_W-1:0]   req_bytes [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign req_bytes[g] = bus.req_data_i[g*DATA_W +: DATA_W];
    end

    // First valid requester scanning upward from rr_ptr with wrap.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_sum  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_sum = {1'b0, rr_q} + (PTR_W+1)'(k);
            if (scan_sum >= NUM_REQ_W) begin
                scan_sum = scan_sum - NUM_REQ_W;
            end
            if (!win_found && bus.req_valid_i[scan_sum[PTR_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = scan_sum[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        own_sum  = {1'b0, own_q} + (PTR_W+1)'(1);
        own_next = (own_sum == NUM_REQ_W) ? '0 : own_sum[PTR_W-1:0];
    end

    assign keep_going = bus.req_lock_i[own_q] && bus.req_valid_i[own_q] &&
                        (burst_q < BURST_MAX);

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        own_d   = own_q;
        burst_d = burst_q;
        tmo_d   = tmo_q;
        grant_d = grant_q;
        data_d  = data_q;
        ack_d   = '0;
        txen_d  = 1'b0;
        tout_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (win_found && !bus.tx_ing_i) begin
                    own_d   = win_idx;
                    grant_d = ONE_HOT0 << win_idx;
                    ack_d   = ONE_HOT0 << win_idx;
                    data_d  = req_bytes[win_idx];
                    txen_d  = 1'b1;
                    burst_d = 8'd1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                tmo_d   = '0;
                state_d = WAIT_START;
            end
            WAIT_START: begin
                if (bus.tx_ing_i) begin
                    state_d = WAIT_END;
                end else if (tmo_q == TMO_LAST) begin
                    // Transmitter never started: give up and move the pointer on.
                    tout_d  = 1'b1;
                    grant_d = '0;
                    rr_d    = own_next;
                    burst_d = '0;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            WAIT_END: begin
                if (!bus.tx_ing_i) begin
                    if (keep_going) begin
                        ack_d   = ONE_HOT0 << own_q;
                        data_d  = req_bytes[own_q];
                        txen_d  = 1'b1;
                        burst_d = burst_q + 8'd1;
                        state_d = LOAD;
                    end else begin
                        grant_d = '0;
                        rr_d    = own_next;
                        burst_d = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            rr_q    <= '0;
            own_q   <= '0;
            burst_q <= '0;
            tmo_q   <= '0;
            grant_q <= '0;
            ack_q   <= '0;
            data_q  <= '0;
            txen_q  <= 1'b0;
            tout_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            own_q   <= own_d;
            burst_q <= burst_d;
            tmo_q   <= tmo_d;
            grant_q <= grant_d;
            ack_q   <= ack_d;
            data_q  <= data_d;
            txen_q  <= txen_d;
            tout_q  <= tout_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.req_ack_o    = ack_q;
    assign bus.grant_o      = grant_q;
    assign bus.tx_data_o    = data_q;
    assign bus.txen_o       = txen_q;
    assign bus.tx_timeout_o = tout_q;
    assign bus.busy_o       = busy_q;
    assign bus.state_o      = state_q;
    assign bus.rr_ptr_o     = rr_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboarded bench for uart_tx_arbiter: queued requesters, a simple transmitter
// model, and one task per scenario.
module tb_uart_tx_arbiter;
    localparam int NR     = 4;
    localparam int DW     = 8;
    localparam int MB     = 4;
    localparam int ST     = 16;
    localparam int TX_DLY = 2;
    localparam int TX_LEN = 10;
    localparam int EW     = 11;

    logic clock;
    logic reset;

    uart_tx_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ(NR), .DATA_W(DW), .MAX_BURST(MB), .START_TIMEOUT(ST)
    ) dut (
        .clock_i (clock),
        .reset_i (reset),
        .bus     (bus)
    );

    // clock / reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int n_tests = 0;
    int n_fail  = 0;

    logic [EW-1:0] exp_q [$];
    logic [DW-1:0] src_q [NR][$];
    logic [NR-1:0] lock_mode;
    logic          prev_txen;
    logic          tx_alive;
    int            tx_pend;
    int            tx_left;

    function automatic logic all_empty();
        logic r;
        r = 1'b1;
        for (int i = 0; i < NR; i++) if (src_q[i].size() != 0) r = 1'b0;
        return r;
    endfunction

    task automatic expect_byte(input int idx, input logic [DW-1:0] d);
        exp_q.push_back({3'(idx), d});
    endtask

    task automatic load(input int idx, input logic [DW-1:0] d);
        src_q[idx].push_back(d);
    endtask

    // One cycle: scoreboard at the negedge, then requesters and transmitter model.
    task automatic tick();
        logic [EW-1:0] e;
        logic [NR-1:0] oh;
        @(negedge clock);
        if (!reset) begin
            if (bus.txen_o || bus.req_ack_o != '0) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected: ack=%b txen=%b data=%h, no byte expected",
                             bus.req_ack_o, bus.txen_o, bus.tx_data_o);
                end else begin
                    e  = exp_q.pop_front();
                    oh = 4'b0001 << e[10:8];
                    if (bus.txen_o !== 1'b1 || bus.req_ack_o !== oh ||
                        bus.grant_o !== oh || bus.tx_data_o !== e[7:0]) begin
                        n_fail++;
                        $display("FAIL sb_byte: txen=%b ack=%b grant=%b data=%h, required txen=1 ack=%b grant=%b data=%h",
                                 bus.txen_o, bus.req_ack_o, bus.grant_o, bus.tx_data_o, oh, oh, e[7:0]);
                    end
                end
                n_tests++;
                if (prev_txen) begin
                    n_fail++;
                    $display("FAIL txen_consecutive: txen high on two cycles in a row");
                end
            end
        end
        prev_txen = bus.txen_o;
        for (int i = 0; i < NR; i++) begin
            if (bus.req_ack_o[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
            bus.req_valid_i[i]          = (src_q[i].size() != 0);
            bus.req_data_i[i*DW +: DW]  = (src_q[i].size() != 0) ? src_q[i][0] : '0;
            bus.req_lock_i[i]           = lock_mode[i] && (src_q[i].size() != 0);
        end
        if (bus.tx_ing_i) begin
            tx_left--;
            if (tx_left == 0) bus.tx_ing_i = 1'b0;
        end else if (tx_pend > 0) begin
            tx_pend--;
            if (tx_pend == 0 && tx_alive) begin
                bus.tx_ing_i = 1'b1;
                tx_left      = TX_LEN;
            end
        end
        if (bus.txen_o && !reset) tx_pend = TX_DLY;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int i = 0; i < NR; i++) src_q[i].delete();
        exp_q.delete();
        lock_mode    = '0;
        tx_alive     = 1'b1;
        tx_pend      = 0;
        tx_left      = 0;
        bus.tx_ing_i = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!(all_empty() && bus.state_o == 2'd0 && !bus.tx_ing_i && tx_pend == 0) && n < budget) begin
            tick();
            n++;
        end
        n_tests++;
        if (n >= budget) begin
            n_fail++;
            $display("FAIL wait_done: still busy after %0d cycles, state=%0d", n, bus.state_o);
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d expected bytes never issued, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        #1;
        n_tests++;
        if ({bus.grant_o, bus.req_ack_o, bus.tx_data_o, bus.txen_o, bus.tx_timeout_o,
             bus.busy_o, bus.state_o, bus.rr_ptr_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: grant=%b ack=%b data=%h txen=%b tout=%b busy=%b state=%0d rr=%0d, required all 0",
                     bus.grant_o, bus.req_ack_o, bus.tx_data_o, bus.txen_o, bus.tx_timeout_o,
                     bus.busy_o, bus.state_o, bus.rr_ptr_o);
        end
        do_reset();
        repeat (3) tick();
        n_tests++;
        if ({bus.grant_o, bus.txen_o, bus.busy_o, bus.state_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_idle: grant=%b txen=%b busy=%b state=%0d, required all 0",
                     bus.grant_o, bus.txen_o, bus.busy_o, bus.state_o);
        end
    endtask

    task automatic test_single();
        int n;
        int bad;
        do_reset();
        load(0, 8'h55);
        expect_byte(0, 8'h55);
        tick();
        n_tests++;
        if (bus.txen_o !== 1'b0) begin
            n_fail++;
            $display("FAIL single_early: txen=%b in valid cycle, required 0", bus.txen_o);
        end
        tick();
        n_tests++;
        if (bus.txen_o !== 1'b1 || bus.req_ack_o !== 4'b0001 || bus.busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL single_latency: txen=%b ack=%b busy=%b, required 1 0001 1",
                     bus.txen_o, bus.req_ack_o, bus.busy_o);
        end
        tick();
        n_tests++;
        if (bus.txen_o !== 1'b0 || bus.req_ack_o !== 4'b0000 || bus.tx_data_o !== 8'h55) begin
            n_fail++;
            $display("FAIL single_drop: txen=%b ack=%b data=%h, required 0 0000 55",
                     bus.txen_o, bus.req_ack_o, bus.tx_data_o);
        end
        n = 0;
        bad = 0;
        while (!bus.tx_ing_i && n < 20) begin tick(); n++; end
        while (bus.tx_ing_i && n < 60) begin
            tick();
            n++;
            if (bus.grant_o !== 4'b0001 || bus.busy_o !== 1'b1) bad++;
        end
        n_tests++;
        if (bad != 0 || n >= 60) begin
            n_fail++;
            $display("FAIL single_hold: %0d cycles lost grant/busy (n=%0d), required 0", bad, n);
        end
        tick();
        n_tests++;
        if (bus.grant_o !== 4'b0000 || bus.busy_o !== 1'b0 || bus.rr_ptr_o !== 2'd1) begin
            n_fail++;
            $display("FAIL single_release: grant=%b busy=%b rr=%0d, required 0000 0 1",
                     bus.grant_o, bus.busy_o, bus.rr_ptr_o);
        end
        wait_done(100);
    endtask

    task automatic test_fairness();
        do_reset();
        load(0, 8'hA0); load(0, 8'hA0);
        load(1, 8'hA1); load(2, 8'hA2); load(3, 8'hA3);
        expect_byte(0, 8'hA0); expect_byte(1, 8'hA1); expect_byte(2, 8'hA2);
        expect_byte(3, 8'hA3); expect_byte(0, 8'hA0);
        wait_done(600);
    endtask

    task automatic test_rotation();
        do_reset();
        load(2, 8'h22);
        expect_byte(2, 8'h22);
        wait_done(200);
        n_tests++;
        if (bus.rr_ptr_o !== 2'd3) begin
            n_fail++;
            $display("FAIL rotation_ptr: rr=%0d, required 3", bus.rr_ptr_o);
        end
        load(1, 8'h31); load(3, 8'h33);
        expect_byte(3, 8'h33); expect_byte(1, 8'h31);
        wait_done(300);
    endtask

    task automatic test_locked_burst();
        int n;
        int falls;
        int bad;
        logic was_ing;
        do_reset();
        lock_mode[1] = 1'b1;
        load(1, 8'h11); load(1, 8'h22); load(1, 8'h33);
        expect_byte(1, 8'h11); expect_byte(1, 8'h22); expect_byte(1, 8'h33);
        n = 0;
        while (bus.grant_o !== 4'b0010 && n < 10) begin tick(); n++; end
        load(0, 8'h0F);
        expect_byte(0, 8'h0F);
        falls = 0;
        bad = 0;
        while (bus.grant_o !== 4'b0001 && n < 400) begin
            was_ing = bus.tx_ing_i;
            tick();
            n++;
            if (was_ing && !bus.tx_ing_i) falls++;
            if (bus.grant_o !== 4'b0010 && bus.grant_o !== 4'b0000 && bus.grant_o !== 4'b0001) bad++;
            if (bus.grant_o === 4'b0000 && falls < 3) bad++;
        end
        n_tests++;
        if (falls != 3 || bad != 0) begin
            n_fail++;
            $display("FAIL burst_hold: req0 granted after %0d tx_ing falls with %0d bad grant cycles, required 3 and 0",
                     falls, bad);
        end
        wait_done(200);
    endtask

    task automatic test_max_burst();
        do_reset();
        lock_mode[0] = 1'b1;
        for (int i = 0; i < 6; i++) load(0, 8'(8'h40 + i));
        load(1, 8'h51);
        for (int i = 0; i < 4; i++) expect_byte(0, 8'(8'h40 + i));
        expect_byte(1, 8'h51);
        expect_byte(0, 8'h44); expect_byte(0, 8'h45);
        wait_done(800);
    endtask

    task automatic test_timeout();
        int n;
        do_reset();
        tx_alive = 1'b0;
        load(2, 8'h77);
        expect_byte(2, 8'h77);
        n = 0;
        while (!bus.txen_o && n < 10) begin tick(); n++; end
        tick();
        n_tests++;
        if (bus.state_o !== 2'd2) begin
            n_fail++;
            $display("FAIL timeout_entry: state=%0d, required 2", bus.state_o);
        end
        n = 0;
        while (!bus.tx_timeout_o && n < 3*ST) begin tick(); n++; end
        n_tests++;
        if (n != ST) begin
            n_fail++;
            $display("FAIL timeout_delay: pulse after %0d cycles, required %0d", n, ST);
        end
        n_tests++;
        if (bus.grant_o !== 4'b0000 || bus.state_o !== 2'd0 || bus.rr_ptr_o !== 2'd3 || bus.busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_release: grant=%b state=%0d rr=%0d busy=%b, required 0000 0 3 0",
                     bus.grant_o, bus.state_o, bus.rr_ptr_o, bus.busy_o);
        end
        tick();
        n_tests++;
        if (bus.tx_timeout_o !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_width: tout=%b, required 0", bus.tx_timeout_o);
        end
        tx_alive = 1'b1;
        load(0, 8'h80); load(3, 8'h83);
        expect_byte(3, 8'h83); expect_byte(0, 8'h80);
        wait_done(300);
    endtask

    task automatic test_reset_mid();
        int n;
        do_reset();
        load(1, 8'h91);
        expect_byte(1, 8'h91);
        wait_done(200);
        load(2, 8'h92);
        expect_byte(2, 8'h92);
        n = 0;
        while (bus.state_o !== 2'd3 && n < 20) begin tick(); n++; end
        n_tests++;
        if (bus.state_o !== 2'd3 || bus.rr_ptr_o !== 2'd2) begin
            n_fail++;
            $display("FAIL midreset_setup: state=%0d rr=%0d, required 3 2", bus.state_o, bus.rr_ptr_o);
        end
        reset = 1'b1;
        #1;
        n_tests++;
        if ({bus.grant_o, bus.req_ack_o, bus.tx_data_o, bus.txen_o, bus.tx_timeout_o,
             bus.busy_o, bus.state_o, bus.rr_ptr_o} !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs: grant=%b data=%h busy=%b state=%0d rr=%0d, required all 0",
                     bus.grant_o, bus.tx_data_o, bus.busy_o, bus.state_o, bus.rr_ptr_o);
        end
        do_reset();
        load(2, 8'hA5);
        expect_byte(2, 8'hA5);
        wait_done(200);
    endtask

    initial begin
        reset            = 1'b1;
        bus.req_valid_i  = '0;
        bus.req_data_i   = '0;
        bus.req_lock_i   = '0;
        bus.tx_ing_i     = 1'b0;
        lock_mode        = '0;
        prev_txen        = 1'b0;
        tx_alive         = 1'b1;
        tx_pend          = 0;
        tx_left          = 0;
        test_reset();
        test_single();
        test_fairness();
        test_rotation();
        test_locked_burst();
        test_max_burst();
        test_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter among NUM_REQ byte requesters. The transmitter's interface is tx_data / txen / tx_ing.
- Arbitration is round-robin. A requester can lock the transmitter for multi-byte bursts, up to MAX_BURST bytes.
- For each byte, the block sequences a txen strobe and then tracks tx_ing until that byte finishes transmitting.
- A start timeout stops the arbiter hanging on a dead transmitter.
- Sits between agent-level message sources and the uart transmitter core.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, byte width.
- MAX_BURST, 16, max bytes per locked tenure before forced release (1..255).
- START_TIMEOUT, 16, cycles allowed after txen for tx_ing to rise (1..255).

Ports:
- clock_i  in  1  system clock, rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- req_valid_i  in  NUM_REQ  per-requester byte valid; held until matching ack.
- req_data_i  in  NUM_REQ*DATA_W  packed bytes; requester i occupies bits [i*DATA_W +: DATA_W].
- req_lock_i  in  NUM_REQ  requester asks to keep the grant after the current byte.
- req_ack_o  out  NUM_REQ  one-cycle pulse; byte accepted and issued to the transmitter.
- grant_o  out  NUM_REQ  one-hot current owner; zero when idle.
- tx_data_o  out  DATA_W  byte to transmitter.
- txen_o  out  1  one-cycle transmit strobe.
- tx_ing_i  in  1  transmitter busy.
- tx_timeout_o  out  1  one-cycle pulse on start timeout.
- busy_o  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async, active-high):
  - state=IDLE, rr_ptr=0, burst_cnt=0, timeout counter=0.
  - All outputs 0, including tx_data_o.
  - Reset mid-operation aborts immediately. A byte already on the line is not tracked.
- All outputs are registered.
- States: IDLE, LOAD, WAIT_START, WAIT_END.
- IDLE:
  - Grants only if any req_valid_i is set and tx_ing_i=0.
  - Winner W is the first valid index searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - On that edge: grant_o<=onehot(W), tx_data_o<=req_data[W], txen_o<=1, req_ack_o[W]<=1, burst_cnt<=1, state<=LOAD.
  - Latency: valid seen in cycle N, so txen_o and ack are high in cycle N+1.
- LOAD:
  - Exactly one cycle. txen_o and req_ack_o drop next edge; tx_data_o holds.
  - Goes to WAIT_START and clears the timeout counter.
- WAIT_START:
  - If tx_ing_i=1: go to WAIT_END.
  - Else the counter increments each cycle.
  - When the counter reaches START_TIMEOUT-1 with tx_ing_i still 0: pulse tx_timeout_o, clear grant_o, rr_ptr<=(W+1)%NUM_REQ, go to IDLE.
- WAIT_END, on the cycle tx_ing_i is sampled 0:
  - Continue condition: req_lock_i[W]=1 and req_valid_i[W]=1 and burst_cnt<MAX_BURST.
  - If continue: tx_data_o<=req_data[W], txen_o<=1, req_ack_o[W]<=1, burst_cnt+=1, state<=LOAD. grant_o is unchanged.
  - Else release: grant_o<=0, rr_ptr<=(W+1)%NUM_REQ, burst_cnt<=0, state<=IDLE. A new grant needs at least one cycle in IDLE.
- Lock and valid are sampled only at the WAIT_END exit decision.
  - Lock dropped earlier but reasserted by then counts as locked.
  - Lock held with valid=0 releases.
- Non-owners' valid and lock inputs are ignored while a grant is held. Non-owners never receive ack.
- After a burst reaching MAX_BURST, the owner is released even if still locked. The owner competes again from the rotated pointer.
- Requests arriving in the same cycle resolve purely by rr_ptr order.
- req_data is sampled only on ack-generating edges. Data changes at other times are ignored.
- At most one bit of req_ack_o is ever high. txen_o is never high on two consecutive cycles.

Test Plan:
- Single byte:
  - Stimulus: req0 valid, data 0x55; model tx_ing rises 2 cycles after txen and lasts 10 cycles.
  - Response: txen_o and ack[0] high one cycle after valid; tx_data_o=0x55; grant_o=0001 until tx_ing falls, then 0000; busy_o tracks the tenure.
- Fairness:
  - Stimulus: all 4 requesters valid continuously with lock=0, data 0xA0+i.
  - Response: bytes issued in order 0xA0, 0xA1, 0xA2, 0xA3, 0xA0; each ack one cycle wide.
- Rotation:
  - Stimulus: only req2 served first, then req1 and req3 valid together.
  - Response: req3 granted first (rr_ptr=3), then req1.
- Locked burst:
  - Stimulus: req1 lock=1 sends 3 bytes 0x11, 0x22, 0x33, dropping lock on the 3rd; req0 valid throughout.
  - Response: grant_o stays 0010 for all three bytes; req0 granted only after the third tx_ing falls.
- Max burst: with MAX_BURST=4, req0 locked and always valid -> forced release after 4 bytes; req1, already waiting, gets the next grant.
- Timeout and reset:
  - Stimulus: tx_ing held 0 after txen.
  - Response: tx_timeout_o pulses exactly START_TIMEOUT cycles after WAIT_START entry; grant cleared; pointer advanced.
  - Stimulus: assert reset_i during WAIT_END.
  - Response: all outputs 0 immediately; state IDLE; rr_ptr 0.
